// File: rtl/irom_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder slice.
package irom_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int INST_W         = 32;
  localparam int DEFAULT_ADDR_W = 14;

  // The wait-state counter is 4 bits wide, which bounds the usable latency.
  localparam int CNT_W          = 4;
  localparam int LATENCY_MIN    = 1;
  localparam int LATENCY_MAX    = 15;

endpackage : irom_responder_pkg

// File: rtl/irom_responder_array.sv
// Instruction storage: DEPTH x 32 words, one synchronous load (write) port
// and one enabled synchronous read port whose output register holds its value
// between reads. A read and write to the same word on one edge returns the
// old contents.
module irom_responder_array
  import irom_responder_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_rdata;

  // Program-load writes; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register samples the array only when the responder enters RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : irom_responder_array

// File: rtl/irom_responder.sv
// Memory-side responder for instruction fetch: accepts one word-addressed
// request at a time, waits LATENCY cycles, then presents the instruction
// until the fetch stage takes it. A flush drops whatever is outstanding.
module irom_responder
  import irom_responder_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_flush,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [INST_W-1:0] o_rsp_inst,
  output logic [ADDR_W-1:0] o_rsp_addr,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [INST_W-1:0] i_ld_data
);

  // Counter value loaded on accept; the WAIT state exits when it reaches 1.
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_accept;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept = i_req_valid && w_req_ready;

  // Entering RESP from WAIT, or a LATENCY==1 accept (possibly back-to-back
  // from RESP); a stalled RESP must not re-sample the array.
  assign w_enter_resp = (w_next_state == RESP) && ((r_state != RESP) || w_accept);

  // With LATENCY==1 the read happens on the accept edge, before r_addr holds it.
  assign w_rd_addr = w_accept ? i_req_addr : r_addr;

  // State, wait counter and request address registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_addr <= i_req_addr;
      end
    end
  end

  // Next-state logic: flush first, then a new accept, then normal progress.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (i_flush) begin
      w_next_state = IDLE;
      w_next_cnt   = '0;
    end else if (w_accept) begin
      if (LATENCY == 1) begin
        w_next_state = RESP;
        w_next_cnt   = '0;
      end else begin
        w_next_state = WAIT;
        w_next_cnt   = LOAD_CNT;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = IDLE;
        end
        WAIT: begin
          w_next_cnt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            w_next_state = IDLE;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    w_rsp_valid = (r_state == RESP);
    w_req_ready = 1'b0;
    if (!i_rst && !i_flush) begin
      w_req_ready = (r_state == IDLE) || ((r_state == RESP) && i_rsp_ready);
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = w_rsp_valid;
  assign o_rsp_addr  = r_addr;

  irom_responder_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_ld_we),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_re    (w_enter_resp),
    .i_raddr (w_rd_addr),
    .o_rdata (o_rsp_inst)
  );

endmodule : irom_responder

// File: tb/tb_irom_responder.sv
// Directed bench for irom_responder: a LATENCY=2 instance carries most of the
// scenarios, a LATENCY=1 instance sharing the load port covers the
// back-to-back case where rsp_valid stays high.
module tb_irom_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ldWe;
  logic [13:0] ldAddr;
  logic [31:0] ldData;

  logic        reqValid, reqReady, rspValid, rspReady;
  logic [13:0] reqAddr, rspAddr;
  logic [31:0] rspInst;

  logic        l1ReqValid, l1ReqReady, l1RspValid, l1RspReady;
  logic [13:0] l1ReqAddr, l1RspAddr;
  logic [31:0] l1RspInst;

  int checks = 0;
  int failures = 0;

  irom_responder #(.ADDR_W(14), .LATENCY(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_addr(reqAddr), .i_flush(flush), .o_rsp_valid(rspValid),
    .i_rsp_ready(rspReady), .o_rsp_inst(rspInst), .o_rsp_addr(rspAddr),
    .i_ld_we(ldWe), .i_ld_addr(ldAddr), .i_ld_data(ldData)
  );

  irom_responder #(.ADDR_W(14), .LATENCY(1)) dutL1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(l1ReqValid), .o_req_ready(l1ReqReady),
    .i_req_addr(l1ReqAddr), .i_flush(flush), .o_rsp_valid(l1RspValid),
    .i_rsp_ready(l1RspReady), .o_rsp_inst(l1RspInst), .o_rsp_addr(l1RspAddr),
    .i_ld_we(ldWe), .i_ld_addr(ldAddr), .i_ld_data(ldData)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [13:0] a, input logic [31:0] d);
    ldWe = 1'b1; ldAddr = a; ldData = d;
    step();
    ldWe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", rspValid); end
    checks++; if (rspInst !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_inst got=%0h exp=0", rspInst); end
    checks++; if (rspAddr !== 14'h0) begin failures++; $display("[TB] FAIL reset_rsp_addr got=%0h exp=0", rspAddr); end
    checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready got=%0h exp=0", reqReady); end
    checks++; if (l1ReqReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_l1_req_ready got=%0h exp=0", l1ReqReady); end
    rst = 1'b0;
    #1;
    checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL release_req_ready got=%0h exp=1", reqReady); end
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL release_rsp_valid got=%0h exp=0", rspValid); end
  endtask

  task automatic test_basic_fetch();
    load(14'd5, 32'h00A0_0093);
    rspReady = 1'b1; reqAddr = 14'd5; reqValid = 1'b1;
    #1;
    checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept_ready got=%0h exp=1", reqReady); end
    step();
    reqValid = 1'b0;
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_t1_valid got=%0h exp=0", rspValid); end
    checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL basic_t1_ready got=%0h exp=0", reqReady); end
    step();
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL basic_t2_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'h00A0_0093) begin failures++; $display("[TB] FAIL basic_t2_inst got=%0h exp=00a00093", rspInst); end
    checks++; if (rspAddr !== 14'd5) begin failures++; $display("[TB] FAIL basic_t2_addr got=%0h exp=5", rspAddr); end
    step();
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_t3_valid got=%0h exp=0", rspValid); end
  endtask

  task automatic test_backpressure();
    load(14'd9, 32'h1111_2222);
    rspReady = 1'b0; reqAddr = 14'd9; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d] got=%0h exp=1", i, rspValid); end
      checks++; if (rspInst !== 32'h1111_2222) begin failures++; $display("[TB] FAIL bp_inst[%0d] got=%0h exp=11112222", i, rspInst); end
      checks++; if (rspAddr !== 14'd9) begin failures++; $display("[TB] FAIL bp_addr[%0d] got=%0h exp=9", i, rspAddr); end
      checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%0h exp=0", i, reqReady); end
      step();
    end
    rspReady = 1'b1;
    #1;
    checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%0h exp=1", reqReady); end
    step();
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle_valid got=%0h exp=0", rspValid); end
    checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL bp_idle_ready got=%0h exp=1", reqReady); end
  endtask

  task automatic test_flush();
    load(14'd7, 32'h0000_0777);
    load(14'd8, 32'h8888_8888);
    rspReady = 1'b1; reqAddr = 14'd7; reqValid = 1'b1;
    step();
    reqValid = 1'b0; flush = 1'b1;
    #1;
    checks++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready got=%0h exp=0", reqReady); end
    step();
    flush = 1'b0;
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_t2_valid got=%0h exp=0", rspValid); end
    reqAddr = 14'd8; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_t3_valid got=%0h exp=0", rspValid); end
    step();
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL flush_t4_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'h8888_8888) begin failures++; $display("[TB] FAIL flush_t4_inst got=%0h exp=88888888", rspInst); end
    checks++; if (rspAddr !== 14'd8) begin failures++; $display("[TB] FAIL flush_t4_addr got=%0h exp=8", rspAddr); end
    step();
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_t5_valid got=%0h exp=0", rspValid); end
  endtask

  task automatic test_back_to_back();
    load(14'd6, 32'h6666_0006);
    rspReady = 1'b1; reqAddr = 14'd5; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    step();
    checks++; if (rspAddr !== 14'd5 || rspValid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first got=%0h/%0h exp=1/5", rspValid, rspAddr); end
    reqAddr = 14'd6; reqValid = 1'b1;
    #1;
    checks++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%0h exp=1", reqReady); end
    step();
    reqValid = 1'b0;
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_valid got=%0h exp=0", rspValid); end
    step();
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'h6666_0006) begin failures++; $display("[TB] FAIL b2b_inst got=%0h exp=66660006", rspInst); end
    checks++; if (rspAddr !== 14'd6) begin failures++; $display("[TB] FAIL b2b_addr got=%0h exp=6", rspAddr); end
    step();
  endtask

  task automatic test_latency1();
    l1RspReady = 1'b1; l1ReqAddr = 14'd5; l1ReqValid = 1'b1;
    step();
    checks++; if (l1RspValid !== 1'b1) begin failures++; $display("[TB] FAIL l1_first_valid got=%0h exp=1", l1RspValid); end
    checks++; if (l1RspInst !== 32'h00A0_0093) begin failures++; $display("[TB] FAIL l1_first_inst got=%0h exp=00a00093", l1RspInst); end
    checks++; if (l1RspAddr !== 14'd5) begin failures++; $display("[TB] FAIL l1_first_addr got=%0h exp=5", l1RspAddr); end
    l1ReqAddr = 14'd6;
    #1;
    checks++; if (l1ReqReady !== 1'b1) begin failures++; $display("[TB] FAIL l1_b2b_ready got=%0h exp=1", l1ReqReady); end
    step();
    l1ReqValid = 1'b0;
    checks++; if (l1RspValid !== 1'b1) begin failures++; $display("[TB] FAIL l1_b2b_valid got=%0h exp=1", l1RspValid); end
    checks++; if (l1RspInst !== 32'h6666_0006) begin failures++; $display("[TB] FAIL l1_b2b_inst got=%0h exp=66660006", l1RspInst); end
    checks++; if (l1RspAddr !== 14'd6) begin failures++; $display("[TB] FAIL l1_b2b_addr got=%0h exp=6", l1RspAddr); end
    step();
    checks++; if (l1RspValid !== 1'b0) begin failures++; $display("[TB] FAIL l1_done_valid got=%0h exp=0", l1RspValid); end
  endtask

  task automatic test_collision();
    rspReady = 1'b1; reqAddr = 14'd5; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    ldWe = 1'b1; ldAddr = 14'd5; ldData = 32'hDEAD_BEEF;
    step();
    ldWe = 1'b0;
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL coll_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'h00A0_0093) begin failures++; $display("[TB] FAIL coll_old_inst got=%0h exp=00a00093", rspInst); end
    step();
    checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL coll_done_valid got=%0h exp=0", rspValid); end
    reqAddr = 14'd5; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    step();
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL coll_refetch_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL coll_new_inst got=%0h exp=deadbeef", rspInst); end
    step();
  endtask

  task automatic test_reset_mid_op();
    load(14'd10, 32'hCAFE_F00D);
    rspReady = 1'b1; reqAddr = 14'd10; reqValid = 1'b1;
    step();
    reqValid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (rspInst !== 32'h0) begin failures++; $display("[TB] FAIL rmid_inst got=%0h exp=0", rspInst); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid[%0d] got=%0h exp=0", i, rspValid); end
      step();
    end
    reqAddr = 14'd10; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    step();
    checks++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL rmid_refetch_valid got=%0h exp=1", rspValid); end
    checks++; if (rspInst !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL rmid_retained got=%0h exp=cafef00d", rspInst); end
    checks++; if (rspAddr !== 14'd10) begin failures++; $display("[TB] FAIL rmid_addr got=%0h exp=a", rspAddr); end
    step();
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1; flush = 1'b0;
    ldWe = 1'b0; ldAddr = '0; ldData = '0;
    reqValid = 1'b0; reqAddr = '0; rspReady = 1'b0;
    l1ReqValid = 1'b0; l1ReqAddr = '0; l1RspReady = 1'b0;
    #1;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_latency1();
    test_collision();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_irom_responder

// File: doc/irom_responder.md
Name: irom_responder

Overview:
- Memory-side responder for instruction fetch. Serves word-addressed fetch requests from the fetch stage over a valid/ready request channel and a valid/ready response channel, after a fixed wait-state latency.
- Holds the instruction array. Provides a program-load write port so a boot loader or testbench can fill the array at run time.
- Replaces the combinational instruction ROM path. The fetch stage becomes the initiator, and this block is the responder.

Parameters:
- ADDR_W, 14, word-address width (byte address bits [15:2]); DEPTH = 2**ADDR_W.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_W  word address of the fetch.
- flush  in  1  fetch redirect; drop the outstanding request.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  fetch stage accepts the response.
- rsp_inst  out  32  instruction word.
- rsp_addr  out  ADDR_W  word address the response belongs to.
- ld_we  in  1  program-load write enable.
- ld_addr  in  ADDR_W  program-load word address.
- ld_data  in  32  program-load data.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE, rsp_valid=0, rsp_inst=0, rsp_addr=0, counter=0.
  - req_ready=0 while rst is high.
  - Array contents are NOT reset.
- FSM states are IDLE, WAIT and RESP. At most one request is outstanding.
- req_ready = !rst && !flush && (state==IDLE || (state==RESP && rsp_ready)).
- Accept: req_valid && req_ready at cycle t.
  - Latch req_addr into an address register.
  - If LATENCY==1, go to RESP at t+1.
  - Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT: counter decrements each cycle. When counter==1, the next state is RESP. rsp_valid first rises at cycle t+LATENCY.
- Array read: mem[addr_reg] is sampled on the edge that enters RESP and registered into rsp_inst. rsp_addr=addr_reg.
- RESP:
  - rsp_valid=1. rsp_inst and rsp_addr are held stable until the rsp_valid && rsp_ready handshake.
  - On handshake with no new accept, go to IDLE (rsp_valid=0 next cycle).
  - On handshake with a same-cycle accept, treat it as a fresh accept from t. rsp_valid drops for at least one cycle when LATENCY>=2. For LATENCY==1, rsp_valid may stay high with the new data.
- flush has priority over all other events. It takes effect in any state:
  - Next state is IDLE and rsp_valid=0 next cycle.
  - Any pending or presented response is discarded and never delivered.
  - A request presented in the same cycle is not accepted (req_ready=0).
- Load port:
  - ld_we writes mem[ld_addr]<=ld_data on the clk edge, in any FSM state.
  - If a write and the response-sampling edge hit the same address in the same cycle, read-before-write applies: rsp_inst gets the old data.
  - ld_we never affects req_ready.
- Addresses cover the full DEPTH, so there are no out-of-range cases. Counter width is 4 bits.
- Reset mid-WAIT or mid-RESP: the request is abandoned, no response is produced, and the array is retained.

Decomposition:
- Shared package:
  - state enum {IDLE, WAIT, RESP}.
  - INST_W=32.
  - Default ADDR_W=14.
  - LATENCY legal bounds.
- Sub-module irom_array:
  - DEPTH x 32 storage.
  - One synchronous write port (ld_*).
  - One synchronous read port with read-before-write, enable driven by the FSM's enter-RESP condition.
- The FSM, counter and handshake logic stay in irom_responder.

Test Plan:
- Reset: hold rst 2 cycles, then release. Required: rsp_valid=0, rsp_inst=0, req_ready=0 during reset; req_ready=1 on the first cycle after release.
- Basic fetch (LATENCY=2): load mem[5]=0x00A00093, then request addr 5 at cycle t with rsp_ready=1. Required: rsp_valid=1 at t+2 only, rsp_inst=0x00A00093, rsp_addr=5; req_ready=0 at t+1.
- Backpressure: hold rsp_ready=0 for 3 cycles during RESP. Required: rsp_valid, rsp_inst and rsp_addr stable; req_ready=0. After raising rsp_ready, the handshake completes and the state returns to IDLE.
- Flush: request addr 7 at t, assert flush at t+1. Required: no rsp_valid ever for addr 7. A request for addr 8 at t+2 responds at t+4 with mem[8].
- Back-to-back: in RESP, rsp_ready=1 and req_valid with addr 6 in the same cycle. Required: accepted that cycle; response for addr 6 arrives LATENCY cycles later. With LATENCY=1, rsp_valid stays high and the data changes to mem[6].
- Write collision / reset mid-op:
  - ld_we to addr 5 with 0xDEADBEEF on the RESP-entry edge of a fetch to 5. Required: old data returned; a re-fetch of 5 returns 0xDEADBEEF.
  - rst asserted in WAIT. Required: no response; the array is unchanged afterwards.
